adder32_arb: RTL and testbench
==============================

Name: adder32_arb

Overview:
Round-robin arbiter that shares one registered 32-bit add-with-carry datapath among NREQ requesters. Each requester presents operands on a valid/ready handshake. The block grants one requester per cycle and performs a + b + c_in. It returns the 33-bit result, tagged with the requester index, through a single-entry output register on a valid/ready handshake. It sits between the client units and the downstream result consumer.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester index; must equal clog2(NREQ)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-requester operand valid
req_ready  output  NREQ  per-requester grant/accept, one-hot or zero
req_a  input  NREQ*32  operand A, requester i at bits [32i+31:32i]
req_b  input  NREQ*32  operand B, same packing
req_cin  input  NREQ  carry-in, bit i for requester i
rsp_valid  output  1  result register holds a valid result
rsp_ready  input  1  consumer accepts result
rsp_id  output  IDW  index of requester that produced result
rsp_sum  output  32  sum bits [31:0]
rsp_cout  output  1  carry out (bit 32)
txn_count  output  16  completed accept count, wraps

Behaviour:
- Reset, asynchronous on rst high:
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, txn_count=0.
  - Round-robin pointer = 0, so requester 0 has highest priority.
  - req_ready=0 while rst is high.
  - Any result held at reset is discarded.
- Output slot states:
  - EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - Slot is "free" when EMPTY, or when FULL and rsp_ready=1 in the same cycle (drain and refill in one cycle).
- Arbitration, combinational:
  - When the slot is free, the grant goes to the first requester with req_valid=1, searching from the pointer upward with wrap NREQ-1 -> 0.
  - req_ready[g]=1 for that requester only. All other req_ready=0.
  - When the slot is not free, req_ready=0 for all requesters.
  - req_ready depends on req_valid and rsp_ready; there is no combinational path from req_a/req_b.
- Accept: a transfer occurs when req_valid[g] && req_ready[g]. On that rising edge:
  - {rsp_cout, rsp_sum} <= req_a[g] + req_b[g] + req_cin[g], computed at 33 bits with no truncation of the carry.
  - rsp_id <= g; rsp_valid <= 1; txn_count <= txn_count + 1, where 0xFFFF wraps to 0.
  - Pointer <= (g+1) mod NREQ.
- Latency: one cycle, accept edge to rsp_valid.
- Throughput: one result per cycle when rsp_ready stays 1.
- Drain without refill: FULL, rsp_ready=1 and no valid request -> next state EMPTY, rsp_valid=0.
- Backpressure: FULL with rsp_ready=0 -> rsp_* hold stable and the pointer holds.
- Requester rules:
  - Once req_valid[i] is asserted, it must stay high with stable operands until accepted.
  - The arbiter must not starve: any continuously valid requester is granted within NREQ accepts.
- Idle pointer: with no request valid, the pointer does not move.
- Reset mid-operation: a pending ungranted request or a held result is lost. No response is emitted for it after reset release.

Test Plan:
- Reset, then req 0 alone with a=0x0000_0001, b=0x0000_0002, cin=1, rsp_ready=1 -> req_ready=0001 same cycle; next cycle rsp_valid=1, id=0, sum=0x0000_0004, cout=0, txn_count=1.
- Carry out: req 2 with a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1, id=2. Then a=b=0xFFFF_FFFF, cin=1 -> sum=0xFFFF_FFFF, cout=1.
- Fairness: all four requesters held valid, rsp_ready=1 -> grant order 0,1,2,3,0 on consecutive cycles and rsp_id follows the same sequence with one-cycle lag.
- Backpressure: result FULL, rsp_ready=0 for 3 cycles with req 1 valid -> req_ready=0 and rsp_* unchanged. Then rsp_ready=1 -> req 1 is granted that same cycle and its result appears next cycle.
- Reset mid-operation: assert rst while rsp_valid=1 and req 3 is waiting -> rsp_valid drops without waiting for a clock edge and txn_count=0. After release, the first grant goes to the lowest-index valid requester.
- Counter wrap: issue 65536 accepts -> txn_count returns to 0x0000. The pointer wraps from 3 to 0 throughout without skipping a requester.

Source files
------------

// File: rtl/adder32_arb.sv
// Round-robin shared 33-bit adder: grants one of NREQ requesters per cycle into a single-entry result register.
// Latency 1 cycle accept-to-rsp_valid; a full slot with rsp_ready=0 blocks all grants and freezes the pointer.
module adder32_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  input  logic [NREQ-1:0]    req_cin,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_sum,
  output logic               rsp_cout,
  output logic [15:0]        txn_count
);

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gnt_id;
  logic [NREQ-1:0] gnt_oh;
  logic            gnt_vld;
  logic            slot_free;
  logic            accept;
  logic [31:0]     a_sel;
  logic [31:0]     b_sel;
  logic            cin_sel;
  logic [32:0]     sum33;

  // First valid requester at or above the pointer, wrapping; depends only on req_valid and ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    gnt_oh  = '0;
    for (int k = 0; k < NREQ; k++) begin
      int unsigned idx;
      idx = (int'(ptr) + k) % NREQ;
      if (!gnt_vld && req_valid[idx]) begin
        gnt_vld     = 1'b1;
        gnt_id      = IDW'(idx);
        gnt_oh[idx] = 1'b1;
      end
    end
  end

  assign slot_free = !rsp_valid || rsp_ready;
  assign req_ready = (slot_free && !rst) ? gnt_oh : '0;
  assign accept    = |req_ready;

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    cin_sel = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_oh[k]) begin
        a_sel   = req_a[k*32 +: 32];
        b_sel   = req_b[k*32 +: 32];
        cin_sel = req_cin[k];
      end
    end
  end

  assign sum33 = {1'b0, a_sel} + {1'b0, b_sel} + {32'd0, cin_sel};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      txn_count <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gnt_id;
      rsp_sum   <= sum33[31:0];
      rsp_cout  <= sum33[32];
      txn_count <= txn_count + 16'd1;
      ptr       <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder32_arb.sv
// Directed bench for adder32_arb with a per-cycle reference model of the arbiter and result slot.
module tb_adder32_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    req_cin;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_sum;
  logic               rsp_cout;
  logic [15:0]        txn_count;

  int checks   = 0;
  int failures = 0;

  adder32_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic cin);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_cin[i]        = cin;
    req_valid[i]      = 1'b1;
  endtask

  // Reference model: slot contents, accept count and priority pointer as plain integers.
  bit          m_valid;
  int          m_id;
  logic [32:0] m_sum;
  int          m_cnt;
  int          m_ptr;

  initial begin
    int          g;
    bit          free;
    bit          s_rdy;
    logic [31:0] s_a, s_b;
    logic        s_cin;
    m_valid = 0; m_id = 0; m_sum = '0; m_cnt = 0; m_ptr = 0;
    forever begin
      @(negedge clk);
      g = -1;
      s_rdy = rsp_ready;
      if (rst) begin
        m_valid = 0; m_id = 0; m_sum = '0; m_cnt = 0; m_ptr = 0;
        chk("m_rst_ready", req_ready, 0);
        chk("m_rst_valid", rsp_valid, 0);
        chk("m_rst_count", txn_count, 0);
      end else begin
        free = !m_valid || rsp_ready;
        if (free) begin
          for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
          end
        end
        chk("m_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
        chk("m_valid", rsp_valid, m_valid);
        chk("m_count", txn_count, m_cnt % 65536);
        if (m_valid) begin
          chk("m_id", rsp_id, m_id);
          chk("m_sum", {rsp_cout, rsp_sum}, m_sum);
        end
        if (g >= 0) begin
          s_a   = req_a[g*32 +: 32];
          s_b   = req_b[g*32 +: 32];
          s_cin = req_cin[g];
        end
      end
      @(posedge clk);
      if (rst) begin
        m_valid = 0; m_id = 0; m_sum = '0; m_cnt = 0; m_ptr = 0;
      end else if (g >= 0) begin
        m_valid = 1;
        m_id    = g;
        m_sum   = 33'(longint'(s_a) + longint'(s_b) + longint'(s_cin));
        m_cnt   = m_cnt + 1;
        m_ptr   = (g + 1) % NREQ;
      end else if (s_rdy) begin
        m_valid = 0;
      end
    end
  end

  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
    rsp_ready = 1'b1;
    tick(); tick();
    chk("reset_valid", rsp_valid, 0);
    chk("reset_sum", rsp_sum, 0);
    chk("reset_count", txn_count, 0);
    chk("reset_ready", req_ready, 0);
    rst = 1'b0;

    // Single request from requester 0: 1 + 2 + 1.
    set_req(0, 32'h1, 32'h2, 1'b1);
    @(negedge clk);
    chk("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("t1_valid", rsp_valid, 1);
    chk("t1_id", rsp_id, 0);
    chk("t1_sum", rsp_sum, 32'h4);
    chk("t1_cout", rsp_cout, 0);
    chk("t1_count", txn_count, 1);

    // Carry out cases on requester 2.
    set_req(2, 32'hFFFF_FFFF, 32'h0, 1'b1);
    @(negedge clk);
    chk("t2_ready", req_ready, 4'b0100);
    tick();
    chk("t2_sum", rsp_sum, 32'h0);
    chk("t2_cout", rsp_cout, 1);
    chk("t2_id", rsp_id, 2);
    set_req(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    tick();
    req_valid = '0;
    chk("t3_sum", rsp_sum, 32'hFFFF_FFFF);
    chk("t3_cout", rsp_cout, 1);
    chk("t3_count", txn_count, 3);

    // Requester 3 alone moves the pointer back to 0.
    set_req(3, 32'h10, 32'h20, 1'b0);
    tick();
    req_valid = '0;
    chk("t4_sum", rsp_sum, 32'h30);

    // Fairness with all requesters held valid.
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i * 16), 32'h1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("fair_ready", req_ready, 64'd1 << order[c]);
      tick();
      chk("fair_id", rsp_id, order[c]);
    end
    req_valid = '0;

    // Backpressure: requester 1 waits while the slot holds requester 0's result.
    rsp_ready = 1'b0;
    set_req(1, 32'h1234, 32'h1111, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_ready", req_ready, 0);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, 0);
      chk("bp_sum", rsp_sum, 32'h1);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", req_ready, 4'b0010);
    tick();
    chk("bp_release_id", rsp_id, 1);
    chk("bp_release_sum", rsp_sum, 32'h2345);
    chk("bp_release_count", txn_count, 10);

    // Reset while a result is held and requester 3 waits.
    req_valid = '0;
    rsp_ready = 1'b0;
    set_req(3, 32'h5, 32'h6, 1'b0);
    @(negedge clk);
    chk("mid_ready", req_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_async_valid", rsp_valid, 0);
    chk("mid_async_count", txn_count, 0);
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    set_req(1, 32'h7, 32'h8, 1'b1);
    @(negedge clk);
    chk("post_rst_ready", req_ready, 4'b0010);
    chk("post_rst_valid", rsp_valid, 0);
    tick();
    req_valid = '0;
    chk("post_rst_id", rsp_id, 1);
    chk("post_rst_sum", rsp_sum, 32'h10);
    chk("post_rst_count", txn_count, 1);
    tick();
    chk("drain_valid", rsp_valid, 0);

    // Counter wrap over 65536 back-to-back accepts with rotating grants.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i), 32'h100, 1'b1);
    for (int c = 0; c < 65536; c++) begin
      @(negedge clk);
      chk("wrap_ready", req_ready, 64'd1 << (c % NREQ));
      tick();
      if (c == 65534) chk("wrap_ffff", txn_count, 16'hFFFF);
    end
    chk("wrap_zero", txn_count, 0);
    req_valid = '0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
